fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of instruction_memory: owns the PC, drives it to the
//  memory's asynchronous read port, captures the returned 24-bit word into an IF/ID register and
//  hands it to decode over a valid/ready handshake. Supports branch redirect (flush) and HALT stop.
// PARAMETERS
//  PC_W        8       PC / instruction-memory address width
//  INSTR_W     24      instruction word width
//  OPC_MSB     23      opcode field MSB in instruction word
//  OPC_LSB     16      opcode field LSB
//  HALT_OPC    8'hFF   opcode that stops fetching
//  RESET_PC    8'h00   PC value loaded on reset
// PORTS
//  clk            in   1        clock, all state updates on rising edge
//  rst            in   1        synchronous, active-high reset
//  imem_pc        out  PC_W     address to instruction memory (= PC register)
//  imem_instr     in   INSTR_W  instruction memory read data, combinational from imem_pc
//  redirect_valid in   1        branch/jump taken from a later stage
//  redirect_pc    in   PC_W     redirect target address
//  dec_valid      out  1        IF/ID register holds a valid instruction
//  dec_ready      in   1        decode accepts word this cycle
//  dec_instr      out  INSTR_W  IF/ID instruction
//  dec_pc         out  PC_W     address the IF/ID instruction was fetched from
//  halted         out  1        HALT fetched; no further fetches
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc<=RESET_PC, dec_valid<=0, dec_instr<=0, dec_pc<=0, state<=RUN,
//    halted=0. rst mid-operation discards IF/ID content and any HALTED state.
//  - States: RUN, HALTED. halted = (state==HALTED). Outputs are registered; imem_pc = pc.
//  - Priority per edge: rst > redirect_valid > fetch/advance > hold.
//  - Redirect: pc<=redirect_pc, dec_valid<=0 (flush, regardless of dec_ready), state<=RUN.
//    Redirect in HALTED resumes fetch (HALT was wrong-path). First redirected word in IF/ID
//    one cycle later -> 2-cycle redirect penalty.
//  - Fetch (RUN, no redirect) when slot free: advance = !dec_valid || dec_ready.
//    On advance: dec_instr<=imem_instr, dec_pc<=pc, dec_valid<=1, pc<=pc+1 (mod 2^PC_W, 8'hFF->8'h00).
//    If imem_instr[OPC_MSB:OPC_LSB]==HALT_OPC: word still delivered to decode, pc NOT
//    incremented, state<=HALTED.
//  - Stall (RUN, dec_valid && !dec_ready): pc, IF/ID, dec_valid all held unchanged; dec_instr stable.
//  - HALTED, no redirect: no fetch; if dec_valid && dec_ready, dec_valid<=0; else hold.
//  - Throughput: one instruction/cycle with dec_ready=1; fetch latency 1 cycle (PC -> dec_instr).
//  - dec_instr/dec_pc do not change while dec_valid && !dec_ready (handshake stability).
// STRUCTURE
//  - fetch_pkg: fetch_state_e {RUN, HALTED}; PC_W, INSTR_W, opcode field bounds, HALT_OPC, RESET_PC.
//  - Top: PC register, next-PC mux (reset/redirect/increment/hold), state FSM.
//  - Sub-module fetch_if_id_reg: valid/ready pipeline register with load, flush and hold controls
//    carrying {dec_pc, dec_instr}.
//  - Bench instantiates fetch_unit + instruction_memory back-to-back (imem_pc -> PC, Instr -> imem_instr).
// TESTING
//  1 Reset: rst=1 two cycles -> imem_pc=00, dec_valid=0, halted=0; release, dec_ready=1 ->
//    dec_pc=00,01,02,03 on consecutive cycles, dec_instr = memory words at 00..03.
//  2 Stall: dec_ready=0 for 3 cycles with dec_pc=02 -> dec_pc/dec_instr held, imem_pc=03 held;
//    dec_ready=1 -> dec_pc=03 next cycle, no word lost or duplicated.
//  3 Redirect: redirect_valid=1, redirect_pc=40 while dec_pc=05 -> next edge dec_valid=0, imem_pc=40;
//    following edge dec_pc=40; redirect during stall also flushes.
//  4 HALT: memory word at 06 = FF_xxxx -> dec_pc=06 delivered with dec_valid=1, halted=1, imem_pc
//    stays 06; after accept dec_valid=0 permanently; redirect_pc=10 -> halted=0, dec_pc=10 next.
//  5 Wrap: redirect_pc=FE, dec_ready=1 -> dec_pc sequence FE, FF, 00, 01.
//  6 Reset mid-run: rst=1 while dec_valid=1 and dec_ready=0 -> dec_valid=0, imem_pc=00 next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Fetch stage shared types and constants.
// State encoding plus instruction field layout.
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 24;
  localparam int OPC_MSB = 23;
  localparam int OPC_LSB = 16;

  localparam logic [OPC_MSB-OPC_LSB:0] HALT_OPC = 8'hFF;
  localparam logic [PC_W-1:0]          RESET_PC = 8'h00;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: valid/ready slot with
// load, flush and consume controls.
module fetch_if_id_reg #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_clear,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr
);

  logic               r_valid;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC mux,
// RUN/HALTED FSM and IF/ID register toward decode.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic               halted
);

  logic [PC_W-1:0] r_pc;
  fetch_state_e    r_state;

  logic w_run;
  logic w_adv;
  logic w_load;
  logic w_clear;
  logic w_halt_opc;

  assign w_run      = (r_state == RUN);
  assign w_adv      = !dec_valid || dec_ready;
  assign w_load     = w_run && w_adv && !redirect_valid;
  assign w_clear    = !w_run && dec_valid && dec_ready;
  assign w_halt_opc = (imem_instr[OPC_MSB:OPC_LSB] == HALT_OPC);

  // HALT word is still delivered, but the PC parks on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= RUN;
    end else if (redirect_valid) begin
      r_pc    <= redirect_pc;
      r_state <= RUN;
    end else if (w_load) begin
      if (w_halt_opc) begin
        r_state <= HALTED;
      end else begin
        r_pc <= r_pc + PC_W'(1);
      end
    end
  end

  fetch_if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (redirect_valid),
    .i_clear (w_clear),
    .i_pc    (r_pc),
    .i_instr (imem_instr),
    .o_valid (dec_valid),
    .o_pc    (dec_pc),
    .o_instr (dec_instr)
  );

  assign imem_pc = r_pc;
  assign halted  = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: behavioural instruction memory
// and a scoreboard of words expected at decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_pc;
  logic [23:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [23:0] dec_instr;
  logic [7:0]  dec_pc;
  logic        halted;

  logic [23:0] mem [256];
  logic [31:0] sb_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_pc];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .halted         (halted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] a);
    sb_q.push_back({a, mem[a]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra_pc", {24'd0, dec_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("sb_pc", {24'd0, dec_pc}, {24'd0, e[31:24]});
        chk("sb_instr", {8'd0, dec_instr}, {8'd0, e[23:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = {1'b0, 7'(i), 8'(i), 8'(~i)};
    end
    mem[6] = 24'hFF_1234;

    rst = 1'b1;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    step();
    step();
    chk("rst_pc", {24'd0, imem_pc}, 32'h00);
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    rst = 1'b0;
    dec_ready = 1'b1;
    push(8'h00); push(8'h01); push(8'h02);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_pc", {24'd0, dec_pc}, 32'(i));
      chk("seq_valid", {31'd0, dec_valid}, 32'd1);
    end

    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_dec_pc", {24'd0, dec_pc}, 32'h02);
      chk("stall_instr", {8'd0, dec_instr}, {8'd0, mem[2]});
      chk("stall_imem_pc", {24'd0, imem_pc}, 32'h03);
    end
    dec_ready = 1'b1;
    push(8'h03); push(8'h04); push(8'h05);
    for (int i = 3; i < 6; i++) begin
      step();
      chk("post_stall_pc", {24'd0, dec_pc}, 32'(i));
    end

    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, dec_valid}, 32'd0);
    chk("redir_imem_pc", {24'd0, imem_pc}, 32'h40);
    step();
    chk("redir_dec_pc", {24'd0, dec_pc}, 32'h40);
    chk("redir_dec_valid", {31'd0, dec_valid}, 32'd1);

    dec_ready = 1'b0;
    step();
    chk("stall2_dec_pc", {24'd0, dec_pc}, 32'h40);
    redirect_valid = 1'b1;
    redirect_pc = 8'h04;
    step();
    redirect_valid = 1'b0;
    chk("stall_redir_valid", {31'd0, dec_valid}, 32'd0);
    chk("stall_redir_pc", {24'd0, imem_pc}, 32'h04);

    dec_ready = 1'b1;
    push(8'h04); push(8'h05); push(8'h06);
    step();
    step();
    step();
    chk("halt_dec_pc", {24'd0, dec_pc}, 32'h06);
    chk("halt_dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_imem_pc", {24'd0, imem_pc}, 32'h06);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halted_valid", {31'd0, dec_valid}, 32'd0);
      chk("halted_flag", {31'd0, halted}, 32'd1);
      chk("halted_imem_pc", {24'd0, imem_pc}, 32'h06);
    end

    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    push(8'h10);
    step();
    redirect_valid = 1'b0;
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_imem_pc", {24'd0, imem_pc}, 32'h10);
    step();
    chk("resume_dec_pc", {24'd0, dec_pc}, 32'h10);

    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    push(8'hFE); push(8'hFF); push(8'h00);
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_fe", {24'd0, dec_pc}, 32'hFE);
    step();
    chk("wrap_ff", {24'd0, dec_pc}, 32'hFF);
    step();
    chk("wrap_00", {24'd0, dec_pc}, 32'h00);
    step();
    chk("wrap_01", {24'd0, dec_pc}, 32'h01);
    dec_ready = 1'b0;
    step();
    chk("pre_rst_valid", {31'd0, dec_valid}, 32'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", {31'd0, dec_valid}, 32'd0);
    chk("midrst_imem_pc", {24'd0, imem_pc}, 32'h00);
    chk("midrst_halted", {31'd0, halted}, 32'd0);
    dec_ready = 1'b1;
    push(8'h00);
    step();
    chk("midrst_dec_pc", {24'd0, dec_pc}, 32'h00);
    step();
    dec_ready = 1'b0;
    step();
    chk("sb_left", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
